stream_mux_arb: RTL
===================

// Module: stream_mux_arb
// PURPOSE
// - N:1 word multiplexer with valid/ready handshake on every channel and a registered output stage.
// - Generalises the 2:1 datapath mux to N channels of WIDTH bits.
// - Two selection modes: an external select, or fair round-robin among requesting channels.
// - Sits between multiple producers (e.g. fetch/LSU request sources) and one shared consumer port.
// PARAMETERS
// - WIDTH    32  data bits per channel
// - N        4   number of input channels (>=2)
// - RR_MODE  0   0 = channel chosen by sel input; 1 = round-robin arbitration (sel ignored)
// - SEL_W    $clog2(N)  localparam; width of sel/out_sel
// PORTS
// - clk        in   1        clock, all state on rising edge
// - rst        in   1        asynchronous reset, active-high
// - sel        in   SEL_W    channel select (RR_MODE=0 only)
// - in_valid   in   N        per-channel valid
// - in_data    in   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
// - in_ready   out  N        per-channel ready
// - out_valid  out  1        output register holds a word
// - out_data   out  WIDTH    registered output word
// - out_sel    out  SEL_W    index of the channel that produced out_data
// - out_ready  in   1        consumer accepts word
// BEHAVIOUR
// - Reset (async assert, sync use after release):
//   - out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
//   - in_ready=0 while rst is high.
// - Output register load enable: ld = !out_valid || out_ready (a one-entry pipeline stage).
// - Grant g (combinational, at most one hot):
//   - RR_MODE=0: g = sel, if sel < N and in_valid[sel]. sel >= N means no grant, and all in_ready=0.
//   - RR_MODE=1: g = first i with in_valid[i], scanning i = rr_ptr, rr_ptr+1, ... with wrap modulo N.
//   - No valid channel means no grant.
// - in_ready[i] = ld && (i==g) && grant_exists. Ready does not depend on in_valid[i] for i != g.
// - Transfer in: in_valid[g] && in_ready[g].
//   - Next cycle: out_valid=1, out_data=in_data[g], out_sel=g.
//   - Latency is 1 clk input->output.
// - Transfer out: out_valid && out_ready.
//   - If no simultaneous transfer in, out_valid=0 next cycle. out_data/out_sel hold their last value.
//   - Simultaneous in+out transfers give full throughput: 1 word/clk, no bubble.
// - Backpressure: while out_valid && !out_ready, all in_ready=0 and out_data/out_sel/out_valid stay stable.
// - rr_ptr (RR_MODE=1):
//   - On each transfer in, rr_ptr = (g==N-1) ? 0 : g+1 (wrap).
//   - Unchanged otherwise, including when stalled.
//   - With all N channels continuously valid, grants rotate 0,1,..,N-1,0; no channel waits more than N-1 transfers.
// - sel may change every cycle. A word already in the output register is unaffected.
// - Reset mid-transfer drops the held word (out_valid=0). Producers must re-present it.
// - Inputs are only sampled on a transfer in. No combinational path from out_ready to out_data.
// - There is a combinational path from out_ready and in_valid/sel to in_ready.
// TESTING
// - T1 reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_sel=0, in_ready=0 immediately; after release first word passes with 1-clk latency.
// - T2 RR_MODE=0, N=4: sel=2, in_valid=4'b0100, in_data[2]=0xDEADBEEF, out_ready=1 -> next clk out_valid=1, out_data=0xDEADBEEF, out_sel=2; sel=3 with in_valid[3]=0 -> in_ready=0, no transfer.
// - T3 backpressure: out_valid=1, out_ready=0 for 5 clks, inputs changing -> out_data/out_sel constant, in_ready=4'b0000; out_ready=1 with sel valid -> in+out same clk, no bubble.
// - T4 RR_MODE=1: in_valid=4'b1111 held, out_ready=1 for 8 clks -> out_sel sequence 0,1,2,3,0,1,2,3 on consecutive clks.
// - T5 RR_MODE=1: rr_ptr=3, in_valid=4'b0011 -> grant 0 (wrap), then rr_ptr=1 -> grant 1, then grant 0.
// - T6 random: random in_valid/out_ready/sel 10k clks vs scoreboard -> no loss, no duplication, per-channel order kept, out stable under stall.

Source files
------------

// File: rtl/stream_mux_arb.sv
// N:1 stream multiplexer with a valid/ready handshake on every channel.
// The channel is picked either by an external select or by fair round-robin.
// The chosen word goes into a one-entry registered output stage.
module stream_mux_arb #(
    parameter int WIDTH   = 32,
    parameter int N       = 4,
    parameter int RR_MODE = 0,
    localparam int SEL_W  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    // Stage p0: combinational grant and input mux. Stage p1: output register.
    logic               ld_p0;
    logic               gnt_vld_p0;
    logic [SEL_W-1:0]   gnt_p0;
    logic               xfer_p0;
    logic [WIDTH-1:0]   data_p0;

    logic               vld_p1;
    logic [WIDTH-1:0]   data_p1;
    logic [SEL_W-1:0]   sel_p1;
    logic [SEL_W-1:0]   rr_ptr;

    // Channel visited k steps after ptr, wrapping modulo N.
    function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= N) s = s - N;
        return SEL_W'(s);
    endfunction

    // Pointer position just after the channel that was granted.
    function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] g);
        return (g == SEL_W'(N - 1)) ? '0 : g + SEL_W'(1);
    endfunction

    // The output register can take a new word when it is empty or being drained.
    assign ld_p0   = !vld_p1 || out_ready;
    assign xfer_p0 = ld_p0 && gnt_vld_p0;

    // Grant: the external select, or the first valid channel at or after rr_ptr.
    always_comb begin
        gnt_vld_p0 = 1'b0;
        gnt_p0     = '0;
        if (RR_MODE == 0) begin
            if (int'(sel) < N && in_valid[sel]) begin
                gnt_vld_p0 = 1'b1;
                gnt_p0     = sel;
            end
        end else begin
            // Scan from farthest to nearest so the nearest valid channel wins.
            for (int k = N - 1; k >= 0; k--) begin
                if (in_valid[rr_idx(rr_ptr, k)]) begin
                    gnt_vld_p0 = 1'b1;
                    gnt_p0     = rr_idx(rr_ptr, k);
                end
            end
        end
    end

    // Data mux for the granted channel.
    always_comb begin
        data_p0 = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_p0 == SEL_W'(i)) data_p0 = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Only the granted channel sees ready; nothing is ready while reset is held.
    always_comb begin
        in_ready = '0;
        if (!rst && xfer_p0) in_ready[gnt_p0] = 1'b1;
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            sel_p1  <= '0;
            rr_ptr  <= '0;
        end else begin
            if (xfer_p0) begin
                vld_p1  <= 1'b1;
                data_p1 <= data_p0;
                sel_p1  <= gnt_p0;
            end else if (out_ready) begin
                vld_p1  <= 1'b0;
            end
            if (RR_MODE != 0 && xfer_p0) rr_ptr <= rr_next(gnt_p0);
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_sel   = sel_p1;

endmodule
